// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants, parser state encoding and hex helpers for the UART
// register-command parser.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_Q  = 8'h3F;
    localparam logic [7:0] ASCII_W  = 8'h57;
    localparam logic [7:0] ASCII_R  = 8'h52;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_ADDR,
        ST_W_DH,
        ST_W_DL,
        ST_W_CR,
        ST_R_ADDR,
        ST_R_CR,
        ST_SKIP,
        ST_RESP
    } state_e;

    // {valid, nibble}; letters share low-nibble layout in both cases
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'd0;
    endfunction

    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream handshakes between UART receiver, parser and transmitter.
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport slave  (input  rx_data, rx_valid, tx_ready,
                    output rx_ready, tx_data, tx_valid);
    modport master (output rx_data, rx_valid, tx_ready,
                    input  rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/uart_resp_buf.sv
// Three-byte response buffer: loaded with 2 or 3 bytes, streams them out
// over valid/ready and flags the final handshake.
module uart_resp_buf (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic [1:0]      load_cnt,
    input  logic [2:0][7:0] load_data,
    input  logic            tx_ready,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    output logic            done
);
    logic [2:0][7:0] mem_q;
    logic [1:0]      cnt_q;
    logic [1:0]      idx_q;
    logic            last;

    assign tx_valid = (cnt_q != 2'd0);
    assign tx_data  = mem_q[idx_q];
    assign last     = (idx_q == cnt_q - 2'd1);
    assign done     = tx_valid && tx_ready && last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q <= '0;
            cnt_q <= 2'd0;
            idx_q <= 2'd0;
        end else if (load) begin
            mem_q <= load_data;
            cnt_q <= load_cnt;
            idx_q <= 2'd0;
        end else if (tx_valid && tx_ready) begin
            if (last) begin
                cnt_q <= 2'd0;
                idx_q <= 2'd0;
            end else begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end
endmodule

// File: rtl/uart_cmd_parser.sv
// Line-oriented serial-console register interface: parses W/R commands,
// owns the register file, the inter-byte timeout and the error counter.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int NREG           = 8,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic                 clk,
    input  logic                 rstn,
    uart_cmd_parser_if.slave     bus,
    output logic [NREG*8-1:0]    regs_flat,
    output logic [7:0]           err_cnt
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      regs_q [NREG];
    logic [TW-1:0]   tmo_q;
    logic            alive_q;
    logic            acc, addr_ok, tmo_hit, wr_en, err_inc, ld, resp_done;
    logic [4:0]      hx;
    logic [7:0]      rv, rxb;
    logic [1:0]      ld_cnt;
    logic [2:0][7:0] ld_data;

    // alive_q keeps rx_ready low while reset is held
    assign bus.rx_ready = alive_q && (state_q != ST_RESP);
    assign acc     = bus.rx_valid && bus.rx_ready;
    assign rxb     = bus.rx_data;
    assign hx      = hex2nib(rxb);
    assign addr_ok = hx[4] && (32'(hx[3:0]) < NREG);
    assign rv      = regs_q[addr_q];
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1)) && !acc;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_en   = 1'b0;
        err_inc = 1'b0;
        ld      = 1'b0;
        ld_cnt  = 2'd2;
        ld_data = '0;
        if (tmo_hit) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
        end else if (acc) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rxb == ASCII_W || rxb == (ASCII_W | 8'h20))      state_d = ST_W_ADDR;
                    else if (rxb == ASCII_R || rxb == (ASCII_R | 8'h20)) state_d = ST_R_ADDR;
                    else if (rxb != ASCII_CR && rxb != ASCII_LF && rxb != ASCII_SP)
                        state_d = ST_SKIP;
                end
                ST_W_ADDR, ST_R_ADDR: begin
                    addr_d  = hx[AW-1:0];
                    state_d = !addr_ok ? ST_SKIP : (state_q == ST_W_ADDR) ? ST_W_DH : ST_R_CR;
                end
                ST_W_DH: begin
                    data_d[7:4] = hx[3:0];
                    state_d     = hx[4] ? ST_W_DL : ST_SKIP;
                end
                ST_W_DL: begin
                    data_d[3:0] = hx[3:0];
                    state_d     = hx[4] ? ST_W_CR : ST_SKIP;
                end
                ST_W_CR: begin
                    state_d = ST_SKIP;
                    if (rxb == ASCII_CR) begin
                        wr_en   = 1'b1;
                        ld      = 1'b1;
                        ld_data = {8'h00, ASCII_LF, ASCII_K};
                        state_d = ST_RESP;
                    end
                end
                ST_R_CR: begin
                    state_d = ST_SKIP;
                    if (rxb == ASCII_CR) begin
                        ld      = 1'b1;
                        ld_cnt  = 2'd3;
                        ld_data = {ASCII_LF, nib2hex(rv[3:0]), nib2hex(rv[7:4])};
                        state_d = ST_RESP;
                    end
                end
                ST_SKIP: begin
                    if (rxb == ASCII_CR) begin
                        ld      = 1'b1;
                        err_inc = 1'b1;
                        ld_data = {8'h00, ASCII_LF, ASCII_Q};
                        state_d = ST_RESP;
                    end
                end
                default: ;
            endcase
        end
        if (state_q == ST_RESP && resp_done)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            alive_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tmo_q <= '0;
        else if (acc || tmo_hit || state_q == ST_IDLE || state_q == ST_RESP)
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= 8'h00;
            for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
        end else begin
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
            if (wr_en) regs_q[addr_q] <= data_q;
        end
    end

    for (genvar i = 0; i < NREG; i++) begin : g_flat
        assign regs_flat[8*i +: 8] = regs_q[i];
    end

    uart_resp_buf u_resp (
        .clk       (clk),
        .rstn      (rstn),
        .load      (ld),
        .load_cnt  (ld_cnt),
        .load_data (ld_data),
        .tx_ready  (bus.tx_ready),
        .tx_valid  (bus.tx_valid),
        .tx_data   (bus.tx_data),
        .done      (resp_done)
    );
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a line-level command model queues
// expected response bytes; a monitor pops them at each tx handshake.
module tb_uart_cmd_parser;
    localparam int NREG = 8;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [NREG*8-1:0] regs_flat;
    logic [7:0] err_cnt;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(.NREG(NREG), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .regs_flat (regs_flat),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tx_mode = 0;               // 0 always ready, 1 random, 2 held low
    int m_err   = 0;
    logic [7:0] m_regs [NREG];
    logic [7:0] line [$];
    logic [7:0] exp_q [$];
    logic [7:0] cq [$];
    string hs      = "0123456789ABCDEF";
    string bad_ltr = "Xq5!";
    string bad_hex = "gZ:@G";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hexv(input logic [7:0] c);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] u;
            u = hs[i];
            if (c == u || (i >= 10 && c == u + 8'h20)) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREG*8-1:0] m_flat();
        logic [NREG*8-1:0] f;
        for (int i = 0; i < NREG; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    function automatic logic is_w(input logic [7:0] c); return c == "W" || c == "w"; endfunction
    function automatic logic is_r(input logic [7:0] c); return c == "R" || c == "r"; endfunction

    // Whole-line evaluation: leading CR/LF/SP dropped, line closed by CR.
    task automatic model_byte(input logic [7:0] b);
        int a;
        if (line.size() == 0 && (b == 8'h0D || b == 8'h0A || b == 8'h20)) return;
        if (b != 8'h0D) begin
            line.push_back(b);
            return;
        end
        a = (line.size() >= 2) ? hexv(line[1]) : -1;
        if (line.size() == 4 && is_w(line[0]) && a >= 0 && a < NREG &&
            hexv(line[2]) >= 0 && hexv(line[3]) >= 0) begin
            m_regs[a] = 8'(hexv(line[2]) * 16 + hexv(line[3]));
            exp_q.push_back("K");
            exp_q.push_back(8'h0A);
        end else if (line.size() == 2 && is_r(line[0]) && a >= 0 && a < NREG) begin
            exp_q.push_back(hs[m_regs[a] / 16]);
            exp_q.push_back(hs[m_regs[a] % 16]);
            exp_q.push_back(8'h0A);
        end else begin
            exp_q.push_back("?");
            exp_q.push_back(8'h0A);
            if (m_err < 255) m_err++;
        end
        line.delete();
    endtask

    // Monitor: compares each handshaken byte and checks stall behaviour.
    logic stall_prev = 1'b0;
    logic [7:0] held;
    always @(negedge clk) begin
        if (!rstn) begin
            stall_prev = 1'b0;
        end else if (bus.tx_valid) begin
            check("rx_ready_in_resp", {63'd0, bus.rx_ready}, 64'd0);
            if (stall_prev) check("tx_hold", {56'd0, bus.tx_data}, {56'd0, held});
            if (bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got 0x%0h, want no byte at %0t", bus.tx_data, $time);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("tx_byte", {56'd0, bus.tx_data}, {56'd0, e});
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                held = bus.tx_data;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        case (tx_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = 1'($urandom_range(0, 1));
            default: bus.tx_ready = 1'b0;
        endcase
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.rx_ready) begin
                model_byte(b);
                break;
            end
            k++;
            if (k > 2000) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_accept: rx_ready stuck 0, want 1 within 2000 cycles");
                break;
            end
        end
    endtask

    task automatic gap(input int n);
        if (n == 0) return;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    // Idle long enough to exceed the inter-byte timeout by a wide margin.
    task automatic long_gap();
        gap(30);
        if (line.size() != 0) begin
            line.delete();
            if (m_err < 255) m_err++;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        while ((exp_q.size() != 0 || bus.tx_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d bytes still pending, want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check("regs_flat", 64'(regs_flat), 64'(m_flat()));
        check("err_cnt", {56'd0, err_cnt}, 64'(m_err));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        send_byte(8'h0D);
    endtask

    function automatic logic [7:0] hch(input int v);
        logic [7:0] c;
        c = hs[v];
        if (v >= 10 && $urandom_range(0, 1) == 1) c = c + 8'h20;
        return c;
    endfunction

    // Generated commands never contain CR; the caller appends it.
    task automatic gen_cmd();
        int kind;
        logic [7:0] wc, rc;
        kind = $urandom_range(0, 6);
        wc = ($urandom_range(0, 1) == 1) ? "W" : "w";
        rc = ($urandom_range(0, 1) == 1) ? "R" : "r";
        cq.delete();
        repeat ($urandom_range(0, 2)) cq.push_back(($urandom_range(0, 1) == 1) ? 8'h20 : 8'h0A);
        case (kind)
            0: begin cq.push_back(wc); cq.push_back(hch($urandom_range(0, NREG - 1)));
                     cq.push_back(hch($urandom_range(0, 15))); cq.push_back(hch($urandom_range(0, 15))); end
            1: begin cq.push_back(rc); cq.push_back(hch($urandom_range(0, NREG - 1))); end
            2: begin cq.push_back(wc); cq.push_back(hch($urandom_range(NREG, 15)));
                     cq.push_back(hch($urandom_range(0, 15))); cq.push_back(hch($urandom_range(0, 15))); end
            3: begin cq.push_back(wc); cq.push_back(hch($urandom_range(0, NREG - 1)));
                     cq.push_back(hch($urandom_range(0, 15))); cq.push_back(bad_hex[$urandom_range(0, 4)]); end
            4: begin cq.push_back(bad_ltr[$urandom_range(0, 3)]); cq.push_back(hch($urandom_range(0, 15))); end
            5: begin cq.push_back(rc); cq.push_back(hch($urandom_range(0, NREG - 1)));
                     cq.push_back(hch($urandom_range(0, 15))); end
            default: begin cq.push_back(rc); cq.push_back(hch($urandom_range(NREG, 15))); end
        endcase
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int plen;
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
        check("rst_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
        check("rst_tx_data", {56'd0, bus.tx_data}, 64'd0);
        check("rst_regs", 64'(regs_flat), 64'd0);
        check("rst_err", {56'd0, err_cnt}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_rx_ready", {63'd0, bus.rx_ready}, 64'd1);

        // basic write, read-back, rejected commands
        send_str("W3A5"); drain();
        check("t1_reg3", {56'd0, regs_flat[31:24]}, 64'hA5);
        send_str("r3"); drain();
        send_str("W9FF"); drain();
        send_str("Wg"); drain();
        check("t3_err", {56'd0, err_cnt}, 64'd2);

        // back-pressure with bytes offered on rx
        tx_mode = 2;
        send_str("R2");
        @(posedge clk); #1;
        bus.rx_data  = "W";
        bus.rx_valid = 1'b1;
        @(negedge clk);
        check("t4_valid", {63'd0, bus.tx_valid}, 64'd1);
        check("t4_data", {56'd0, bus.tx_data}, 64'h30);
        repeat (49) @(negedge clk);
        check("t4_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
        bus.rx_valid = 1'b0;
        tx_mode = 0;
        drain();
        check("t4_rx_ready_after", {63'd0, bus.rx_ready}, 64'd1);

        // inter-byte timeout
        send_byte("W"); send_byte("1");
        long_gap();
        drain();
        send_str("R1"); drain();

        // reset in the middle of a response
        send_str("W05C"); drain();
        tx_mode = 2;
        send_str("R0");
        @(posedge clk); #3;
        check("t6_pre_valid", {63'd0, bus.tx_valid}, 64'd1);
        rstn = 1'b0;
        #1;
        check("t6_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
        check("t6_regs", 64'(regs_flat), 64'd0);
        check("t6_err", {56'd0, err_cnt}, 64'd0);
        exp_q.delete();
        line.delete();
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_err = 0;
        bus.rx_valid = 1'b0;
        tx_mode = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("t6_rx_ready", {63'd0, bus.rx_ready}, 64'd1);
        send_str("R0"); drain();

        // randomized traffic with random back-pressure and gaps
        tx_mode = 1;
        for (int i = 0; i < 150; i++) begin
            gen_cmd();
            if ($urandom_range(0, 14) == 0) begin
                plen = $urandom_range(1, cq.size());
                for (int j = 0; j < plen; j++) begin
                    send_byte(cq[j]);
                    gap($urandom_range(0, 2));
                end
                long_gap();
            end else begin
                foreach (cq[j]) begin
                    send_byte(cq[j]);
                    gap($urandom_range(0, 2));
                end
                send_byte(8'h0D);
            end
            drain();
        end

        // error counter saturation
        tx_mode = 0;
        for (int i = 0; i < 262; i++) begin
            send_str("?");
            drain();
        end
        check("err_sat", {56'd0, err_cnt}, 64'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
